axi_read_responder: RTL and testbench

- AXI read-channel responder (slave) for the 256-bit DRAM-side interface driven by the reference-reader arbiter.
- Accepts AR requests into an in-order request FIFO and serves each burst from an internal 256-bit-wide synchronous RAM.
- Returns R beats with the originating ID and RLAST.
- Serves as the on-chip reference store in system builds and as the memory model in arbiter/reader benches; a host-side load port preloads reference data.

---
 rtl/axi_read_responder.sv | 218 +++++++++++++++++++++
 tb/tb_axi_read_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// AXI read-channel responder: in-order AR request FIFO feeding a 256-bit synchronous RAM,
// returning R beats through a two-entry output buffer. A load port preloads RAM contents.
module axi_read_responder #(
    parameter int MEM_AW    = 10,
    parameter int REQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           axi_arid_in,
    input  logic [31:0]          axi_araddr_in,
    input  logic [7:0]           axi_arlen_in,
    input  logic                 axi_arvalid_in,
    output logic                 axi_arready_out,
    output logic [7:0]           axi_rid_out,
    output logic [255:0]         axi_rdata_out,
    output logic                 axi_rvalid_out,
    output logic                 axi_rlast_out,
    input  logic                 axi_rready_in,
    input  logic                 ld_en_in,
    input  logic [MEM_AW-1:0]    ld_addr_in,
    input  logic [255:0]         ld_data_in
);
    localparam int PW = $clog2(REQ_DEPTH);
    localparam int EW = 8 + MEM_AW + 8;
    localparam logic [PW:0] FULL_CNT = REQ_DEPTH[PW:0];

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    // ---------------- request FIFO ----------------
    logic [EW-1:0]     r_fifo [REQ_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic [PW:0]       w_count_next;
    logic              r_arready;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [EW-1:0]     w_head;
    logic [7:0]        w_head_id;
    logic [MEM_AW-1:0] w_head_idx;
    logic [7:0]        w_head_len;
    logic              w_unused_addr;

    assign w_push       = axi_arvalid_in & r_arready;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_id    = w_head[EW-1 -: 8];
    assign w_head_idx   = w_head[MEM_AW+7:8];
    assign w_head_len   = w_head[7:0];
    // Sub-word offset and bits beyond the RAM size do not select anything
    assign w_unused_addr = ^{axi_araddr_in[31:MEM_AW+5], axi_araddr_in[4:0]};

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {axi_arid_in, axi_araddr_in[MEM_AW+4:5], axi_arlen_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_arready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= w_count_next;
            r_arready <= (w_count_next != FULL_CNT);
        end
    end

    assign axi_arready_out = r_arready;

    // ---------------- RAM ----------------
    logic [255:0]      r_mem [2**MEM_AW];
    logic [255:0]      r_ram_q;
    logic              w_rd_en;
    logic [MEM_AW-1:0] w_rd_idx;
    logic [7:0]        w_rd_id;
    logic              w_rd_last;

    // Nonblocking write and read in one process: a same-word read sees the old data
    always_ff @(posedge clk) begin
        if (ld_en_in) r_mem[ld_addr_in] <= ld_data_in;
        if (w_rd_en)  r_ram_q <= r_mem[w_rd_idx];
    end

    // ---------------- output buffer ----------------
    // Slot A is the RAM output register; slot B holds an older beat displaced by a new read.
    logic         r_a_valid;
    logic [7:0]   r_a_id;
    logic         r_a_last;
    logic         r_b_valid;
    logic [7:0]   r_b_id;
    logic         r_b_last;
    logic [255:0] r_b_data;
    logic         w_out_valid;
    logic         w_out_fire;
    logic         w_slot_ok;

    assign w_out_valid = r_a_valid | r_b_valid;
    assign w_out_fire  = w_out_valid & axi_rready_in;
    assign w_slot_ok   = !(r_a_valid && r_b_valid) || w_out_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_id    <= '0;
            r_a_last  <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_id    <= '0;
            r_b_last  <= 1'b0;
            r_b_data  <= '0;
        end else if (w_rd_en) begin
            r_a_valid <= 1'b1;
            r_a_id    <= w_rd_id;
            r_a_last  <= w_rd_last;
            if (r_a_valid && !(w_out_fire && !r_b_valid)) begin
                r_b_valid <= 1'b1;
                r_b_id    <= r_a_id;
                r_b_last  <= r_a_last;
                r_b_data  <= r_ram_q;
            end else if (r_b_valid && w_out_fire) begin
                r_b_valid <= 1'b0;
            end
        end else if (w_out_fire) begin
            if (r_b_valid) r_b_valid <= 1'b0;
            else           r_a_valid <= 1'b0;
        end
    end

    assign axi_rvalid_out = w_out_valid;
    assign axi_rid_out    = r_b_valid ? r_b_id   : (r_a_valid ? r_a_id  : 8'd0);
    assign axi_rdata_out  = r_b_valid ? r_b_data : (r_a_valid ? r_ram_q : 256'd0);
    assign axi_rlast_out  = r_b_valid ? r_b_last : (r_a_valid & r_a_last);

    // ---------------- burst sequencer ----------------
    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_id;
    logic [7:0]        w_id_next;
    logic [MEM_AW-1:0] r_idx;
    logic [MEM_AW-1:0] w_idx_next;
    logic [7:0]        r_remaining;
    logic [7:0]        w_remaining_next;

    always_comb begin
        w_state_next     = r_state;
        w_id_next        = r_id;
        w_idx_next       = r_idx;
        w_remaining_next = r_remaining;
        w_pop            = 1'b0;
        w_rd_en          = 1'b0;
        w_rd_idx         = r_idx;
        w_rd_id          = r_id;
        w_rd_last        = (r_remaining == 8'd0);
        case (r_state)
            S_IDLE: begin
                // First beat reads straight from the FIFO head to save a cycle
                if (!w_fifo_empty && w_slot_ok) begin
                    w_pop            = 1'b1;
                    w_rd_en          = 1'b1;
                    w_rd_idx         = w_head_idx;
                    w_rd_id          = w_head_id;
                    w_rd_last        = (w_head_len == 8'd0);
                    w_id_next        = w_head_id;
                    w_idx_next       = w_head_idx + 1'b1;
                    w_remaining_next = (w_head_len == 8'd0) ? 8'd0 : w_head_len - 8'd1;
                    if (w_head_len != 8'd0) w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_slot_ok) begin
                    w_rd_en = 1'b1;
                    if (r_remaining == 8'd0) begin
                        if (!w_fifo_empty) begin
                            w_pop            = 1'b1;
                            w_id_next        = w_head_id;
                            w_idx_next       = w_head_idx;
                            w_remaining_next = w_head_len;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_idx_next       = r_idx + 1'b1;
                        w_remaining_next = r_remaining - 8'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_next;
            r_id        <= w_id_next;
            r_idx       <= w_idx_next;
            r_remaining <= w_remaining_next;
        end
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: latency, streaming, backpressure, FIFO full,
// ordering, index wrap and mid-burst reset.
module tb_axi_read_responder;
    localparam int MEM_AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        axi_arid_in;
    logic [31:0]       axi_araddr_in;
    logic [7:0]        axi_arlen_in;
    logic              axi_arvalid_in;
    logic              axi_arready_out;
    logic [7:0]        axi_rid_out;
    logic [255:0]      axi_rdata_out;
    logic              axi_rvalid_out;
    logic              axi_rlast_out;
    logic              axi_rready_in;
    logic              ld_en_in;
    logic [MEM_AW-1:0] ld_addr_in;
    logic [255:0]      ld_data_in;

    int checks   = 0;
    int failures = 0;

    logic [255:0] model [1024];
    logic [7:0]   q_id [$];
    logic [255:0] q_data [$];
    logic         q_last [$];

    always #5 clk = ~clk;

    axi_read_responder #(.MEM_AW(MEM_AW), .REQ_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .axi_arid_in    (axi_arid_in),
        .axi_araddr_in  (axi_araddr_in),
        .axi_arlen_in   (axi_arlen_in),
        .axi_arvalid_in (axi_arvalid_in),
        .axi_arready_out(axi_arready_out),
        .axi_rid_out    (axi_rid_out),
        .axi_rdata_out  (axi_rdata_out),
        .axi_rvalid_out (axi_rvalid_out),
        .axi_rlast_out  (axi_rlast_out),
        .axi_rready_in  (axi_rready_in),
        .ld_en_in       (ld_en_in),
        .ld_addr_in     (ld_addr_in),
        .ld_data_in     (ld_data_in)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [255:0] d);
        ld_en_in   = 1'b1;
        ld_addr_in = MEM_AW'(a);
        ld_data_in = d;
        model[a]   = d;
        tick();
        ld_en_in   = 1'b0;
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        axi_arid_in    = id;
        axi_araddr_in  = addr;
        axi_arlen_in   = len;
        axi_arvalid_in = 1'b1;
        while (!ok && n < 200) begin
            ok = (axi_arready_out === 1'b1);
            tick();
            n++;
        end
        axi_arvalid_in = 1'b0;
        chk("ar_accept", 256'(ok), 256'(1));
    endtask

    task automatic expect_burst(input logic [7:0] id, input int word, input int len, input int n);
        for (int i = 0; i < n; i++) begin
            q_id.push_back(id);
            q_data.push_back(model[(word + i) % 1024]);
            q_last.push_back(i == len);
        end
    endtask

    // Holds rready high and requires every queued beat on consecutive cycles
    task automatic stream_expect(input string tag, input int max_wait);
        int n;
        n = 0;
        axi_rready_in = 1'b1;
        while (axi_rvalid_out !== 1'b1 && n < max_wait) begin
            tick();
            n++;
        end
        while (q_id.size() > 0) begin
            chk({tag, "_rvalid"}, 256'(axi_rvalid_out), 256'(1));
            chk({tag, "_rid"},    256'(axi_rid_out),    256'(q_id[0]));
            chk({tag, "_rdata"},  axi_rdata_out,        q_data[0]);
            chk({tag, "_rlast"},  256'(axi_rlast_out),  256'(q_last[0]));
            void'(q_id.pop_front());
            void'(q_data.pop_front());
            void'(q_last.pop_front());
            tick();
        end
    endtask

    initial begin
        int           k;
        int           got;
        logic         hold;
        logic         rr;
        logic [7:0]   s_id;
        logic [255:0] s_data;
        logic         s_last;

        rst            = 1'b1;
        axi_arid_in    = '0;
        axi_araddr_in  = '0;
        axi_arlen_in   = '0;
        axi_arvalid_in = 1'b0;
        axi_rready_in  = 1'b0;
        ld_en_in       = 1'b0;
        ld_addr_in     = '0;
        ld_data_in     = '0;
        for (int i = 0; i < 1024; i++) model[i] = '0;

        tick();
        tick();
        chk("rst_arready", 256'(axi_arready_out), 256'(0));
        chk("rst_rvalid",  256'(axi_rvalid_out),  256'(0));
        chk("rst_rlast",   256'(axi_rlast_out),   256'(0));
        chk("rst_rid",     256'(axi_rid_out),     256'(0));
        chk("rst_rdata",   axi_rdata_out,         256'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_arready", 256'(axi_arready_out), 256'(1));

        for (int w = 0; w < 64; w++) load(w, 256'(w));
        load(5, {32{8'hA5}});
        load(1023, {8{32'hDEAD_03FF}});

        // 1: single beat, latency T+2
        axi_rready_in = 1'b1;
        expect_burst(8'h41, 5, 0, 1);
        do_ar(8'h41, 32'h0000_00A0, 8'd0);
        chk("t1_rvalid_T1", 256'(axi_rvalid_out), 256'(0));
        tick();
        chk("t1_rvalid_T2", 256'(axi_rvalid_out), 256'(1));
        stream_expect("t1", 10);
        chk("t1_no_more_a", 256'(axi_rvalid_out), 256'(0));
        tick();
        chk("t1_no_more_b", 256'(axi_rvalid_out), 256'(0));

        // 2: four-beat burst with rready high
        expect_burst(8'h80, 0, 3, 4);
        do_ar(8'h80, 32'h0, 8'd3);
        stream_expect("t2", 10);
        chk("t2_done", 256'(axi_rvalid_out), 256'(0));

        // 3: same burst with rready pattern 1,0,0
        axi_rready_in = 1'b0;
        expect_burst(8'h80, 0, 3, 4);
        do_ar(8'h80, 32'h0, 8'd3);
        k    = 0;
        got  = 0;
        hold = 1'b0;
        s_id = '0; s_data = '0; s_last = 1'b0;
        while (got < 4 && k < 60) begin
            if (hold) begin
                chk("t3_hold_rvalid", 256'(axi_rvalid_out), 256'(1));
                chk("t3_hold_rid",    256'(axi_rid_out),    256'(s_id));
                chk("t3_hold_rdata",  axi_rdata_out,        s_data);
                chk("t3_hold_rlast",  256'(axi_rlast_out),  256'(s_last));
            end
            rr = ((k % 3) == 0);
            axi_rready_in = rr;
            if (axi_rvalid_out === 1'b1 && rr) begin
                chk("t3_rid",   256'(axi_rid_out),   256'(q_id[0]));
                chk("t3_rdata", axi_rdata_out,       q_data[0]);
                chk("t3_rlast", 256'(axi_rlast_out), 256'(q_last[0]));
                void'(q_id.pop_front());
                void'(q_data.pop_front());
                void'(q_last.pop_front());
                got++;
            end
            hold   = (axi_rvalid_out === 1'b1) && !rr;
            s_id   = axi_rid_out;
            s_data = axi_rdata_out;
            s_last = axi_rlast_out;
            tick();
            k++;
        end
        axi_rready_in = 1'b0;
        chk("t3_beat_count", 256'(got), 256'(4));
        chk("t3_no_extra", 256'(axi_rvalid_out), 256'(0));

        // 4: fill the request FIFO while rready is low
        expect_burst(8'h00, 20, 3, 4);
        expect_burst(8'h41, 24, 3, 4);
        expect_burst(8'h82, 28, 3, 4);
        expect_burst(8'hC3, 32, 3, 4);
        expect_burst(8'h04, 36, 3, 4);
        do_ar(8'h00, 32'd20 << 5, 8'd3);
        do_ar(8'h41, 32'd24 << 5, 8'd3);
        do_ar(8'h82, 32'd28 << 5, 8'd3);
        do_ar(8'hC3, 32'd32 << 5, 8'd3);
        do_ar(8'h04, 32'd36 << 5, 8'd3);
        chk("t4_arready_full", 256'(axi_arready_out), 256'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_arready_stays_low", 256'(axi_arready_out), 256'(0));
            chk("t4_rvalid_held",       256'(axi_rvalid_out),  256'(1));
            chk("t4_rid_held",          256'(axi_rid_out),     256'(8'h00));
        end

        // 5: drain all five bursts back to back
        stream_expect("t5", 5);
        chk("t5_drained", 256'(axi_rvalid_out), 256'(0));
        chk("t5_arready", 256'(axi_arready_out), 256'(1));

        // 6: word index wrap 1023 -> 0, low address bits ignored
        expect_burst(8'h33, 1023, 1, 2);
        do_ar(8'h33, (32'd1023 << 5) | 32'h1F, 8'd1);
        stream_expect("t6", 10);
        chk("t6_done", 256'(axi_rvalid_out), 256'(0));

        // 7: reset after beat 3 of an 8-beat burst, then a fresh request
        expect_burst(8'h15, 40, 7, 3);
        do_ar(8'h15, 32'd40 << 5, 8'd7);
        stream_expect("t7a", 10);
        rst = 1'b1;
        axi_rready_in = 1'b0;
        tick();
        chk("t7_rvalid_after_rst", 256'(axi_rvalid_out),  256'(0));
        chk("t7_arready_in_rst",   256'(axi_arready_out), 256'(0));
        rst = 1'b0;
        tick();
        chk("t7_arready_back", 256'(axi_arready_out), 256'(1));
        chk("t7_no_stale_a",   256'(axi_rvalid_out),  256'(0));
        tick();
        chk("t7_no_stale_b",   256'(axi_rvalid_out),  256'(0));
        axi_rready_in = 1'b1;
        expect_burst(8'h2A, 50, 1, 2);
        do_ar(8'h2A, 32'd50 << 5, 8'd1);
        stream_expect("t7b", 10);
        chk("t7_done", 256'(axi_rvalid_out), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
